// File: rtl/divider_8bit_pkg.sv
// divider_8bit_pkg: shared state encodings and constants for the restoring divider
package divider_8bit_pkg;
    localparam int DW = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [DW-1:0] DIV_ZERO_Q = '1;
    localparam logic DIV_MODE_SIGNED = 1'b1;
endpackage

// File: rtl/divider_8bit_adder.sv
// divider_8bit_adder: add/subtract adder reused as the divider's trial subtractor
module divider_8bit_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Add_mode,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    logic [WIDTH-1:0] b_eff;
    assign b_eff = Add_mode ? B : ~B;
    assign {Cout, Sum} = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Cin};
endmodule

// File: rtl/divider_8bit.sv
// divider_8bit: multi-cycle restoring divider, one quotient bit per clock, unsigned or signed
module divider_8bit
    import divider_8bit_pkg::*;
#(
    parameter int WIDTH = DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Div_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             dz_flag,
    output logic             v_flag
);
    localparam int CW = $clog2(WIDTH) + 1;
    logic [1:0] state;
    logic [CW-1:0] count;
    logic [WIDTH-1:0] dvd, dvs, rem, q, a_raw, diff, a_abs, b_abs;
    logic [WIDTH:0] rem_sh;
    logic neg_q, neg_r, dz, ovf, cout, take, signed_in, a_neg, b_neg;
    assign signed_in = Div_mode == DIV_MODE_SIGNED;
    assign a_neg = signed_in & A[WIDTH-1];
    assign b_neg = signed_in & B[WIDTH-1];
    // the most negative value negates to itself, which read unsigned is its exact magnitude
    assign a_abs = a_neg ? -A : A;
    assign b_abs = b_neg ? -B : B;
    assign rem_sh = {rem, dvd[WIDTH-1]};
    assign take = rem_sh[WIDTH] | cout;
    assign busy = state != S_IDLE;
    divider_8bit_adder #(.WIDTH(WIDTH)) u_sub (
        .A(rem_sh[WIDTH-1:0]),
        .B(dvs),
        .Cin(1'b1),
        .Add_mode(1'b0),
        .Sum(diff),
        .Cout(cout)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            count <= '0;
            dvd <= '0;
            dvs <= '0;
            rem <= '0;
            q <= '0;
            a_raw <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            ovf <= 1'b0;
            done <= 1'b0;
            Quotient <= '0;
            Remainder <= '0;
            dz_flag <= 1'b0;
            v_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && start) begin
                dvd <= a_abs;
                dvs <= b_abs;
                rem <= '0;
                q <= '0;
                count <= '0;
                a_raw <= A;
                neg_q <= a_neg ^ b_neg;
                neg_r <= a_neg;
                dz <= B == '0;
                ovf <= signed_in && A == {1'b1, {(WIDTH-1){1'b0}}} && B == '1;
                state <= (B == '0) ? S_FIN : S_CALC;
            end else if (state == S_CALC) begin
                rem <= take ? diff : rem_sh[WIDTH-1:0];
                q <= {q[WIDTH-2:0], take};
                dvd <= {dvd[WIDTH-2:0], 1'b0};
                count <= count + CW'(1);
                state <= (count == CW'(WIDTH-1)) ? S_FIN : S_CALC;
            end else if (state == S_FIN) begin
                Quotient <= dz ? DIV_ZERO_Q : (neg_q ? -q : q);
                Remainder <= dz ? a_raw : (neg_r ? -rem : rem);
                dz_flag <= dz;
                v_flag <= ovf;
                done <= 1'b1;
                state <= S_IDLE;
            end else begin
                state <= S_IDLE;
            end
        end
    end
endmodule
